// File: rtl/serial_digit_comp_pkg.sv
// Shared types for the digit-serial comparator: FSM states, the running verdict
// encoding, and the mapping from a verdict to the G/E/L output flags.
package serial_digit_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        GT = 2'b01,
        LT = 2'b10
    } verdict_t;

    // Returns {G, E, L}; the unused 2'b11 encoding is treated as equal.
    function automatic logic [2:0] verdict_to_gel(input verdict_t v);
        case (v)
            GT:      return 3'b100;
            LT:      return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/serial_digit_comp_digit_cmp2.sv
// Combinational magnitude comparator for one 2-bit digit pair.
module digit_cmp2 (
    input  logic [1:0] a_dig,
    input  logic [1:0] b_dig,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a_dig > b_dig);
    assign eq = (a_dig == b_dig);
    assign lt = (a_dig < b_dig);

endmodule

// File: rtl/serial_digit_comp.sv
// MSB-first digit-serial comparator: folds per-digit results into a running
// verdict and reports one-hot G/E/L with a done pulse after the last digit.
module serial_digit_comp
    import serial_digit_comp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] a_dig,
    input  logic [1:0] b_dig,
    output logic       busy,
    output logic       done,
    output logic       G,
    output logic       E,
    output logic       L
);

    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    verdict_t        verdict_q, verdict_d;
    logic [2:0]      gel_q, gel_d;
    logic            done_q, done_d;

    logic            gt_w, eq_w, lt_w;
    verdict_t        dig_v;
    logic            accept, last_acc, start_run;

    digit_cmp2 u_cmp (
        .a_dig (a_dig),
        .b_dig (b_dig),
        .gt    (gt_w),
        .eq    (eq_w),
        .lt    (lt_w)
    );

    always_comb begin
        case ({gt_w, eq_w, lt_w})
            3'b100:  dig_v = GT;
            3'b001:  dig_v = LT;
            default: dig_v = EQ;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign last_acc  = accept && (count_q == LAST);
    assign start_run = start && (state_q != RUN);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start in RUN is deliberately ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_acc) state_d = DONE;
            DONE:    if (start)    state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the handshake depends on state alone
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q == RUN);
        done     = done_q;
        {G, E, L} = gel_q;
    end

    // Counter, verdict and result flags. Only the first unequal digit may
    // change the verdict, but every digit is still consumed.
    always_comb begin
        count_d   = count_q;
        verdict_d = verdict_q;
        gel_d     = gel_q;
        done_d    = 1'b0;
        if (start_run) begin
            count_d   = '0;
            verdict_d = EQ;
            gel_d     = 3'b000;
        end else if (accept) begin
            count_d = count_q + CW'(1);
            if (verdict_q == EQ) begin
                verdict_d = dig_v;
            end
            if (last_acc) begin
                gel_d  = verdict_to_gel(verdict_d);
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            verdict_q <= EQ;
            gel_q     <= 3'b000;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            verdict_q <= verdict_d;
            gel_q     <= gel_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_digit_comp.sv
// Directed bench for serial_digit_comp with DIGITS=4 (8-bit operands).
module tb_serial_digit_comp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] a_dig = 2'b00;
    logic [1:0] b_dig = 2'b00;
    logic       busy, done, G, E, L;

    int n_cmp = 0;
    int n_err = 0;

    serial_digit_comp #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_dig    (a_dig),
        .b_dig    (b_dig),
        .busy     (busy),
        .done     (done),
        .G        (G),
        .E        (E),
        .L        (L)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams all four digits MSB first; 'gap' idle cycles between digits,
    // optional start pulse alongside digit index st_idx (-1 = none).
    task automatic stream(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int gap, input int st_idx);
        for (int i = 3; i >= 0; i--) begin
            chk({tag, "_ready"}, int'(in_ready), 1);
            in_valid = 1'b1;
            a_dig    = a[2*i +: 2];
            b_dig    = b[2*i +: 2];
            start    = (st_idx == 3 - i);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (i == 1) chk({tag, "_early_done"}, int'(done), 0);
            if (i > 0) repeat (gap) tick();
        end
    endtask

    task automatic chk_result(input string tag, input int g, input int e, input int l);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_G"}, int'(G), g);
        chk({tag, "_E"}, int'(E), e);
        chk({tag, "_L"}, int'(L), l);
    endtask

    initial begin
        logic [7:0] av, bv;

        rst = 1'b1;
        #12;
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_gel", int'({G, E, L}), 0);

        // Equal operands, back-to-back digits
        do_start();
        chk("eq_busy_run", int'(busy), 1);
        stream("eq", 8'h5A, 8'h5A, 0, -1);
        chk_result("eq", 0, 1, 0);
        tick();
        chk("eq_done_pulse", int'(done), 0);
        chk("eq_hold_E", int'(E), 1);

        // Decision on third digit, gaps, last digit would say LT
        do_start();
        stream("late", 8'hB4, 8'hB2, 2, -1);
        chk_result("late", 1, 0, 0);
        tick();

        // Decided on first digit, still consumes all four
        do_start();
        stream("first", 8'h3F, 8'h40, 0, -1);
        chk_result("first", 0, 0, 1);

        // Start in DONE/IDLE isn't a digit; start during RUN is ignored
        do_start();
        stream("ign", 8'hB4, 8'hB2, 0, 1);
        chk_result("ign", 1, 0, 0);
        do_start();
        chk("b2b_done", int'(done), 0);
        chk("b2b_gel", int'({G, E, L}), 0);
        chk("b2b_busy", int'(busy), 1);
        stream("ff00", 8'hFF, 8'h00, 0, -1);
        chk_result("ff00", 1, 0, 0);

        // start + in_valid together in DONE: that digit must be dropped
        start = 1'b1; in_valid = 1'b1; a_dig = 2'b00; b_dig = 2'b11;
        tick();
        start = 1'b0; in_valid = 1'b0;
        stream("stv", 8'h5A, 8'h5A, 0, -1);
        chk_result("stv", 0, 1, 0);

        // Async reset mid-run, between clock edges
        do_start();
        in_valid = 1'b1; a_dig = 2'b11; b_dig = 2'b00;
        tick(); tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(in_ready), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_gel", int'({G, E, L}), 0);
        #2;
        rst = 1'b0;
        tick();
        chk("arst_idle", int'(busy), 0);
        do_start();
        stream("zero", 8'h00, 8'h00, 0, -1);
        chk_result("zero", 0, 1, 0);

        // Every 2-bit pair decides in the MSB digit
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                av = {a[1:0], 6'b000000};
                bv = {b[1:0], 6'b000000};
                do_start();
                stream("pair", av, bv, 0, -1);
                chk_result($sformatf("pair%0d%0d", a, b),
                           int'(a > b), int'(a == b), int'(a < b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_digit_comp.md
Name: serial_digit_comp

Overview:
- Sequential, MSB-first, digit-serial magnitude comparator for two N-digit operands. Each digit is 2 bits.
- It consumes one 2-bit digit pair per accepted handshake and folds each per-digit greater/equal/less result into a running verdict.
- After the last digit it reports the final G/E/L flags with a one-cycle done pulse.
- It sits downstream of the 2-bit structural comparators and extends them to wide operands streamed from a narrow datapath.

Parameters:
- DIGITS, 4, number of 2-bit digits per operand (operand width = 2*DIGITS). Legal range 2..64.
- CW, $clog2(DIGITS), digit counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new comparison; honoured only in IDLE or DONE.
- in_valid  input  1  a_dig/b_dig carry a valid digit pair.
- in_ready  output  1  block accepts a digit this cycle.
- a_dig  input  2  current digit of operand A, MSB digit first.
- b_dig  input  2  current digit of operand B, MSB digit first.
- busy  output  1  comparison in progress (state RUN).
- done  output  1  one-cycle pulse when the final verdict is written.
- G  output  1  A > B; valid from done until next start.
- E  output  1  A == B; valid from done until next start.
- L  output  1  A < B; valid from done until next start.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, verdict=EQ internally. All outputs are 0: in_ready, busy, done, G, E, L.
- States and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: accept of digit index DIGITS-1 -> DONE.
  - DONE: start=1 -> RUN. Otherwise stay in DONE and hold G/E/L.
- Entering RUN:
  - count<=0, verdict<=EQ.
  - G/E/L cleared to 0 on the same edge.
- in_ready = (state==RUN), combinational from state only. busy = (state==RUN).
- Accept = in_valid & in_ready.
- On accept:
  - If verdict==EQ, verdict <= digit result (GT/EQ/LT). Otherwise verdict is held, because the first unequal digit from the MSB decides.
  - count increments.
  - All DIGITS pairs are always consumed, even after the verdict is decided. There is no early termination.
- Final accept (count==DIGITS-1), on the same edge:
  - G/E/L <= one-hot of the final verdict.
  - done <= 1 for exactly one cycle; state <= DONE.
  - Latency: done is high in the cycle after the last accept.
- in_valid gaps in RUN stall the block. No timeout.
- start while in RUN is ignored. The comparison continues.
- start and in_valid together in IDLE/DONE: no digit is accepted that cycle (in_ready=0). Digit 0 is accepted from the next cycle.
- start in the cycle done is high (state DONE): a new run begins. done is deasserted next cycle and G/E/L are cleared.
- Reset mid-RUN: immediate abort to the reset values. The partial verdict is discarded.
- G/E/L are mutually exclusive and exactly one-hot whenever state==DONE.

Decomposition:
- Package serial_digit_comp_pkg:
  - state enum {IDLE, RUN, DONE}.
  - verdict enum {EQ=2'b00, GT=2'b01, LT=2'b10}.
  - function to map a verdict to the {G,E,L} one-hot.
- Sub-module digit_cmp2: purely combinational 2-bit comparator (a_dig, b_dig -> gt, eq, lt), correct for all 16 input pairs. It is instantiated once. The top holds only the FSM, counter and verdict register.

Test Plan (DIGITS=4):
- Reset then idle: rst pulse, no start -> all outputs 0, in_ready=0.
- Equal operands: start, stream A=B=0x5A as digits 01,01,10,10 back-to-back -> done one cycle after 4th accept, E=1, G=0, L=0; busy low in DONE.
- Late decision with gaps: A=0xB4 (10,11,01,00), B=0xB2 (10,11,00,10), in_valid low 2 cycles between each digit -> G=1, E=0, L=0; the 4th digit (00 vs 10) must not flip the result.
- First-digit decision: A=0x3F (00,11,11,11), B=0x40 (01,00,00,00) -> L=1 after all 4 digits consumed; done asserts only after the 4th accept.
- Ignored start / back-to-back runs:
  - Assert start during digit 2 of a run -> no restart; verdict is correct.
  - Assert start in the done cycle -> G/E/L=0 next cycle.
  - New run A=0xFF, B=0x00 -> G=1.
- Async reset mid-RUN: rst asserted between clock edges after 2 accepts -> outputs 0 immediately, state IDLE. A fresh start with A=B=0x00 gives E=1.
